// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deframe 11-bit frames,
// fold E0/F0 prefixes into key events and queue them in a show-ahead FIFO.
module ps2_keyboard_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2clk,
    input  logic          ps2data,
    input  logic          evt_pop,
    input  logic          ovf_clr,
    output logic          evt_valid,
    output logic [7:0]    evt_code,
    output logic          evt_break,
    output logic          evt_ext,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic          raw_done,
    output logic [7:0]    raw_byte,
    output logic          parity_err,
    output logic          frame_err,
    output logic          timeout_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          flt_clk, strobe;
    logic [FW-1:0] flt_cnt;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          ones, ones_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          done_n, perr_n, ferr_n, terr_n;

    logic          ext_pend, brk_pend;
    logic          push_req, full, do_push, do_pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [9:0]    head;

    // Filtered clock only follows the synced clock after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            flt_clk <= 1'b1;
            flt_cnt <= '0;
            strobe  <= 1'b0;
        end else begin
            clk_s1 <= ps2clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data;
            dat_s2 <= dat_s1;
            strobe <= 1'b0;
            if (clk_s2 == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                flt_clk <= clk_s2;
                flt_cnt <= '0;
                strobe  <= flt_clk;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        ones_n    = ones;
        to_cnt_n  = (state != S_IDLE) ? to_cnt + 1'b1 : to_cnt;
        done_n    = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        terr_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe && !dat_s2) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                    ones_n    = 1'b0;
                    to_cnt_n  = '0;
                end
            end
            S_DATA: begin
                if (strobe) begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    ones_n    = ones ^ dat_s2;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
            end
            S_PARITY: begin
                if (strobe) begin
                    if (ones ^ dat_s2) begin
                        state_n = S_STOP;
                    end else begin
                        perr_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            S_STOP: begin
                if (strobe) begin
                    done_n  = dat_s2;
                    ferr_n  = !dat_s2;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state != S_IDLE) begin
            if (strobe) begin
                to_cnt_n = '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n  = S_IDLE;
                terr_n   = 1'b1;
                to_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            ones        <= 1'b0;
            to_cnt      <= '0;
            raw_done    <= 1'b0;
            raw_byte    <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            ones        <= ones_n;
            to_cnt      <= to_cnt_n;
            raw_done    <= done_n;
            parity_err  <= perr_n;
            frame_err   <= ferr_n;
            timeout_err <= terr_n;
            if (done_n) raw_byte <= shreg;
        end
    end

    // Prefix bytes only arm the pends; any error forgets a half-built event.
    assign push_req = raw_done && (raw_byte != 8'hE0) && (raw_byte != 8'hF0);
    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign do_pop   = evt_pop && (fifo_count != '0);
    assign do_push  = push_req && (!full || evt_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (parity_err || frame_err || timeout_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (raw_done) begin
                if (raw_byte == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (raw_byte == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
            else if (!do_push && do_pop) fifo_count <= fifo_count - 1'b1;
            if (ovf_clr)                               overflow <= 1'b0;
            else if (push_req && full && !evt_pop)     overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {raw_byte, brk_pend, ext_pend};
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_count != '0);
    assign evt_code  = evt_valid ? head[9:2] : 8'h00;
    assign evt_break = evt_valid && head[1];
    assign evt_ext   = evt_valid && head[0];
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Bench for ps2_keyboard_rx_fifo: drives PS/2 frames, models the event stream
// in an expected queue and checks pulses, raw bytes and FIFO behaviour.
module tb_ps2_keyboard_rx_fifo;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int HALF  = 12;

    logic          clk = 1'b0;
    logic          reset, ps2clk, ps2data, evt_pop, ovf_clr;
    logic          evt_valid, evt_break, evt_ext, overflow;
    logic [7:0]    evt_code, raw_byte;
    logic [CW-1:0] fifo_count;
    logic          raw_done, parity_err, frame_err, timeout_err;

    logic [9:0] exp_q[$];
    logic       m_ext, m_brk;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fall = 0;
    int done_cnt = 0, par_cnt = 0, frm_cnt = 0, to_cnt = 0, wide_cnt = 0;
    int cnt_at_done = -1, cnt_after_done = -1;
    logic prev_done = 1'b0, prev_par = 1'b0, prev_frm = 1'b0, prev_to = 1'b0;

    ps2_keyboard_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .evt_pop(evt_pop), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
        .fifo_count(fifo_count), .overflow(overflow), .raw_done(raw_done),
        .raw_byte(raw_byte), .parity_err(parity_err), .frame_err(frame_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (prev_done) cnt_after_done = int'(fifo_count);
        if (raw_done) begin
            done_cnt++;
            cnt_at_done = int'(fifo_count);
        end
        if (parity_err)  par_cnt++;
        if (frame_err)   frm_cnt++;
        if (timeout_err) to_cnt++;
        if ((raw_done && prev_done) || (parity_err && prev_par) ||
            (frame_err && prev_frm) || (timeout_err && prev_to)) wide_cnt++;
        prev_done = raw_done;
        prev_par  = parity_err;
        prev_frm  = frame_err;
        prev_to   = timeout_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2data = v;
        repeat (HALF) tick();
        ps2clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) tick();
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(!bad_stop);
        ps2data = 1'b1;
        repeat (4) tick();
        if (bad_par || bad_stop) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({b, m_brk, m_ext});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        logic [9:0] exp;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (!evt_valid || {evt_code, evt_break, evt_ext} !== exp) begin
                errors++;
                $display("FAIL %s head: got valid=%b evt=%h/%b/%b, expected %h/%b/%b",
                         name, evt_valid, evt_code, evt_break, evt_ext, exp[9:2], exp[1], exp[0]);
            end
            evt_pop = 1'b1;
            tick();
            evt_pop = 1'b0;
        end
        checks++;
        if (evt_valid !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL %s empty: got valid=%b count=%0d, expected 0/0", name, evt_valid, fifo_count);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow} !== '0) begin
            errors++;
            $display("FAIL %s fifo outputs: valid=%b code=%h brk=%b ext=%b count=%0d ovf=%b, expected all 0",
                     name, evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow);
        end
        checks++;
        if ({raw_done, raw_byte, parity_err, frame_err, timeout_err} !== '0) begin
            errors++;
            $display("FAIL %s rx outputs: done=%b byte=%h perr=%b ferr=%b terr=%b, expected all 0",
                     name, raw_done, raw_byte, parity_err, frame_err, timeout_err);
        end
    endtask

    task automatic test_reset();
        check_all_zero("reset");
    endtask

    task automatic test_single_make();
        int d0;
        d0 = done_cnt;
        send_frame(8'h1C, 0, 0);
        checks++;
        if (done_cnt !== d0 + 1 || raw_byte !== 8'h1C) begin
            errors++;
            $display("FAIL make raw: done pulses=%0d byte=%h, expected %0d/1c", done_cnt - d0, raw_byte, 1);
        end
        checks++;
        if (cnt_at_done !== 0 || cnt_after_done !== 1) begin
            errors++;
            $display("FAIL make latency: count at done=%0d next=%0d, expected 0/1", cnt_at_done, cnt_after_done);
        end
        checks++;
        if (fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL make count: got %0d, expected 1", fifo_count);
        end
        drain("make");
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        checks++;
        if (fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL extbrk count: got %0d, expected 1", fifo_count);
        end
        send_frame(8'h1C, 0, 0);
        drain("extbrk");
    endtask

    task automatic test_errors();
        int p0, f0;
        p0 = par_cnt;
        f0 = frm_cnt;
        send_frame(8'h55, 1, 0);
        checks++;
        if (par_cnt !== p0 + 1 || raw_byte !== 8'h1C || fifo_count !== '0) begin
            errors++;
            $display("FAIL parity: pulses=%0d byte=%h count=%0d, expected 1/1c/0", par_cnt - p0, raw_byte, fifo_count);
        end
        send_frame(8'hF0, 0, 0);
        send_frame(8'h33, 1, 0);
        send_frame(8'h32, 0, 0);
        checks++;
        if (par_cnt !== p0 + 2 || fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL parity pend: pulses=%0d count=%0d, expected 2/1", par_cnt - p0, fifo_count);
        end
        drain("parity_pend");
        send_frame(8'h66, 0, 1);
        checks++;
        if (frm_cnt !== f0 + 1 || raw_byte !== 8'h32 || fifo_count !== '0) begin
            errors++;
            $display("FAIL frame: pulses=%0d byte=%h count=%0d, expected 1/32/0", frm_cnt - f0, raw_byte, fifo_count);
        end
    endtask

    task automatic test_timeout_glitch();
        int t0, dt;
        bit seen;
        t0 = to_cnt;
        seen = 0;
        dt = -1;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        for (int k = 0; k < TO + 100; k++) begin
            @(negedge clk);
            if (timeout_err) begin
                seen = 1;
                dt = cyc - last_fall;
                break;
            end
        end
        checks++;
        if (!seen || dt < TO + FL + 1 || dt > TO + FL + 5) begin
            errors++;
            $display("FAIL timeout: seen=%0d delay=%0d, expected 1 and %0d..%0d", seen, dt, TO + FL + 1, TO + FL + 5);
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) tick();
        send_frame(8'h29, 0, 0);
        checks++;
        if (raw_byte !== 8'h29 || to_cnt !== t0 + 1) begin
            errors++;
            $display("FAIL after timeout: byte=%h timeouts=%0d, expected 29/1", raw_byte, to_cnt - t0);
        end
        drain("timeout_frame");
        t0 = to_cnt;
        ps2data = 1'b0;
        ps2clk = 1'b0;
        repeat (2) tick();
        ps2clk = 1'b1;
        repeat (TO + 50) tick();
        ps2data = 1'b1;
        checks++;
        if (to_cnt !== t0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL glitch: timeouts=%0d count=%0d, expected 0/0", to_cnt - t0, fifo_count);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        bit got;
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h11 + 8'(i), 0, 0);
        checks++;
        if (fifo_count !== CW'(DEPTH) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: count=%0d ovf=%b, expected %0d/1", fifo_count, overflow, DEPTH);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({evt_code, evt_break, evt_ext} !== exp) begin
            errors++;
            $display("FAIL overflow head: got %h, expected %h", evt_code, exp[9:2]);
        end
        got = 0;
        fork
            send_frame(8'h16, 0, 0);
            begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge clk);
                    if (raw_done) begin
                        evt_pop = 1'b1;
                        @(posedge clk);
                        #1;
                        evt_pop = 1'b0;
                        got = 1;
                        break;
                    end
                end
            end
        join
        checks++;
        if (!got || fifo_count !== CW'(DEPTH) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL push on pop: seen=%0d count=%0d ovf=%b, expected 1/%0d/1", got, fifo_count, overflow, DEPTH);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b, expected 0", overflow);
        end
        drain("overflow");
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) send_frame(8'h21 + 8'(i), 0, 0);
        checks++;
        if (fifo_count !== CW'(3)) begin
            errors++;
            $display("FAIL pre-reset count: got %0d, expected 3", fifo_count);
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(8'hA3 >> i);
        ps2clk = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("mid reset");
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        tick();
        reset = 1'b0;
        repeat (20) tick();
        send_frame(8'h45, 0, 0);
        checks++;
        if (fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL post-reset count: got %0d, expected 1", fifo_count);
        end
        drain("post_reset");
    endtask

    initial begin
        reset = 1'b1;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        evt_pop = 1'b0;
        ovf_clr = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) tick();
        test_reset();
        reset = 1'b0;
        repeat (10) tick();
        test_single_make();
        test_ext_break();
        test_errors();
        test_timeout_glitch();
        test_overflow();
        test_reset_mid_frame();
        checks++;
        if (wide_cnt !== 0) begin
            errors++;
            $display("FAIL pulse width: %0d multi-cycle pulses, expected 0", wide_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
